// File: rtl/soc_top_if.sv
// soc_top_if: board pin bundle for soc_top (RXD in, TXD and LED out of the SoC)
interface soc_top_if;
  logic       RXD;
  logic       TXD;
  logic [7:0] LED;
  modport master (output RXD, input TXD, input LED);
  modport slave (input RXD, output TXD, output LED);
endinterface

// File: rtl/soc_top.sv
// soc_top: 8N1 UART receiver feeding an LED register and a buffered echo transmitter (ports: CLK, RST active-low async, io.RXD in, io.TXD/io.LED out)
module soc_top #(
  parameter int CLKS_PER_BIT = 8
) (
  input logic       CLK,
  input logic       RST,
  soc_top_if.slave  io
);
  localparam int TW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [TW-1:0] full_t = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] half_t = TW'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t          rx_st, tx_st;
  logic            rx_m, rx_s, rx_valid, txd, buf_full;
  logic [TW-1:0]   rx_tmr, tx_tmr;
  logic [2:0]      rx_idx, tx_idx;
  logic [7:0]      rx_sh, tx_sh, buf_q, led_q;
  assign io.TXD = txd;
  assign io.LED = led_q;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_m     <= 1'b1;
      rx_s     <= 1'b1;
      rx_st    <= IDLE;
      rx_tmr   <= '0;
      rx_idx   <= '0;
      rx_sh    <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_m     <= io.RXD;
      rx_s     <= rx_m;
      rx_valid <= 1'b0;
      rx_tmr   <= rx_tmr + 1'b1;
      case (rx_st)
        IDLE: begin
          rx_tmr <= '0;
          if (!rx_s) rx_st <= START;
        end
        START: if (rx_tmr == half_t) begin
          rx_tmr <= '0;
          rx_idx <= '0;
          rx_st  <= rx_s ? IDLE : DATA;
        end
        DATA: if (rx_tmr == full_t) begin
          rx_tmr <= '0;
          rx_sh  <= {rx_s, rx_sh[7:1]};
          rx_idx <= rx_idx + 1'b1;
          if (rx_idx == 3'd7) rx_st <= STOP;
        end
        STOP: if (rx_tmr == full_t) begin
          rx_tmr   <= '0;
          rx_valid <= rx_s;
          rx_st    <= IDLE;
        end
        default: rx_st <= IDLE;
      endcase
    end
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) led_q <= '0;
    else if (rx_valid) led_q <= rx_sh;
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tx_st    <= IDLE;
      tx_tmr   <= '0;
      tx_idx   <= '0;
      tx_sh    <= '0;
      txd      <= 1'b1;
      buf_full <= 1'b0;
      buf_q    <= '0;
    end else begin
      tx_tmr <= tx_tmr + 1'b1;
      case (tx_st)
        IDLE: begin
          tx_tmr <= '0;
          // buffered byte has priority; a simultaneous new byte takes its slot
          if (buf_full) begin
            tx_sh    <= buf_q;
            tx_st    <= START;
            txd      <= 1'b0;
            buf_full <= rx_valid;
            if (rx_valid) buf_q <= rx_sh;
          end else if (rx_valid) begin
            tx_sh <= rx_sh;
            tx_st <= START;
            txd   <= 1'b0;
          end
        end
        START: if (tx_tmr == full_t) begin
          tx_tmr <= '0;
          tx_idx <= '0;
          txd    <= tx_sh[0];
          tx_st  <= DATA;
        end
        DATA: if (tx_tmr == full_t) begin
          tx_tmr <= '0;
          tx_idx <= tx_idx + 1'b1;
          tx_sh  <= tx_sh >> 1;
          txd    <= (tx_idx == 3'd7) ? 1'b1 : tx_sh[1];
          if (tx_idx == 3'd7) tx_st <= STOP;
        end
        STOP: if (tx_tmr == full_t) begin
          tx_tmr <= '0;
          tx_st  <= IDLE;
        end
        default: tx_st <= IDLE;
      endcase
      // with both slots occupied the new byte is dropped from the echo
      if (tx_st != IDLE && rx_valid && !buf_full) begin
        buf_q    <= rx_sh;
        buf_full <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_soc_top.sv
// tb_soc_top: table-driven and scoreboarded checks of the UART LED/echo SoC top
module tb_soc_top;
  localparam int CPB = 8;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int npass = 0, ntot = 0, cyc = 0, frames = 0;
  int idle_at = 0;
  bit mbuf = 1'b0;
  logic [7:0] expq[$];
  typedef struct {
    logic [7:0] d;
    bit         stop;
    logic [7:0] led;
  } vec_t;
  vec_t tbl[7];
  soc_top_if io();
  soc_top #(.CLKS_PER_BIT(CPB)) dut (.CLK(CLK), .RST(RST), .io(io));
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  // echo model: TX busy for 10 bit periods after load, idle for one cycle, one-entry buffer
  task automatic model_rx(input logic [7:0] d, input int v);
    if (mbuf && idle_at < v) begin
      mbuf = 1'b0;
      idle_at += 10 * CPB + 1;
    end
    if (mbuf && idle_at == v) begin
      idle_at = v + 10 * CPB + 1;
      expq.push_back(d);
    end else if (!mbuf && v >= idle_at) begin
      idle_at = v + 10 * CPB + 1;
      expq.push_back(d);
    end else if (!mbuf) begin
      mbuf = 1'b1;
      expq.push_back(d);
    end
  endtask
  task automatic send(input logic [7:0] d, input bit stop);
    if (stop) model_rx(d, cyc + 79);
    io.RXD = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      io.RXD = d[i];
      repeat (CPB) @(negedge CLK);
    end
    io.RXD = stop;
    repeat (CPB) @(negedge CLK);
    io.RXD = 1'b1;
  endtask
  initial begin
    logic [7:0] d;
    logic sb;
    forever begin
      @(negedge CLK);
      if (RST && io.TXD === 1'b0) begin
        repeat (CPB / 2 - 1) @(negedge CLK);
        chk("tx start bit", io.TXD, 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge CLK);
          d[i] = io.TXD;
        end
        repeat (CPB) @(negedge CLK);
        sb = io.TXD;
        frames++;
        if (expq.size() == 0) begin
          ntot++;
          $display("FAIL tx frame: got unexpected %02h expected none", d);
        end else chk("tx echo {stop,data}", {sb, d}, {1'b1, expq.pop_front()});
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    int bad;
    tbl[0] = '{8'h3C, 1'b0, 8'h00};
    tbl[1] = '{8'hA5, 1'b1, 8'hA5};
    tbl[2] = '{8'h00, 1'b1, 8'h00};
    tbl[3] = '{8'hFF, 1'b1, 8'hFF};
    tbl[4] = '{8'h81, 1'b0, 8'hFF};
    tbl[5] = '{8'h5A, 1'b1, 8'h5A};
    tbl[6] = '{8'hC3, 1'b1, 8'hC3};
    io.RXD = 1'b1;
    RST = 1'b0;
    repeat (5) @(negedge CLK);
    chk("reset LED", io.LED, 8'h00);
    chk("reset TXD", io.TXD, 1'b1);
    RST = 1'b1;
    bad = 0;
    repeat (200) begin
      @(negedge CLK);
      if (io.LED !== 8'h00 || io.TXD !== 1'b1) bad++;
    end
    chk("idle after reset bad cycles", bad, 0);
    foreach (tbl[k]) begin
      send(tbl[k].d, tbl[k].stop);
      repeat (100) @(negedge CLK);
      chk($sformatf("vec%0d LED", k), io.LED, tbl[k].led);
      chk($sformatf("vec%0d TXD idle", k), io.TXD, 1'b1);
    end
    send(8'h12, 1'b1);
    send(8'h34, 1'b1);
    send(8'h56, 1'b1);
    repeat (300) @(negedge CLK);
    chk("back-to-back LED", io.LED, 8'h56);
    chk("back-to-back echoes drained", expq.size(), 0);
    io.RXD = 1'b0;
    repeat (2) @(negedge CLK);
    io.RXD = 1'b1;
    repeat (30) @(negedge CLK);
    chk("false start LED", io.LED, 8'h56);
    send(8'h81, 1'b1);
    repeat (150) @(negedge CLK);
    chk("after false start LED", io.LED, 8'h81);
    chk("echoes drained before reset", expq.size(), 0);
    io.RXD = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      io.RXD = 1'b1;
      repeat (CPB) @(negedge CLK);
    end
    io.RXD = 1'b1;
    repeat (CPB / 2) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("async reset LED", io.LED, 8'h00);
    chk("async reset TXD", io.TXD, 1'b1);
    mbuf = 1'b0;
    idle_at = 0;
    frames = 0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (20) @(negedge CLK);
    send(8'h07, 1'b1);
    repeat (150) @(negedge CLK);
    chk("post-reset LED", io.LED, 8'h07);
    chk("post-reset frame count", frames, 1);
    chk("final echo queue empty", expq.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/soc_top.md
Name: soc_top

Overview:
- Minimal board-level SoC top: an 8N1 UART receiver, an 8N1 UART transmitter and an 8-bit LED register.
- Every correctly framed byte received on RXD is latched onto LED[7:0] and echoed back on TXD.
- A one-entry holding buffer absorbs back-to-back bytes while the transmitter is busy.
- Top-level block of the FPGA design; pins connect directly to board I/O.

Parameters:
- CLKS_PER_BIT, 8, CLK cycles per UART bit period; integer >= 4, even values recommended.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  reset, asynchronous and active-low (0 = in reset); release is synchronous to CLK.
- RXD  input  1  UART serial input, idle high, asynchronous to CLK.
- TXD  output 1  UART serial output, idle high.
- LED  output 8  last correctly received byte.

Behaviour:
- Reset (RST=0, immediately, no clock needed):
  - LED=8'h00, TXD=1.
  - RX and TX FSMs go to IDLE; holding buffer empty; bit counters and timers cleared.
  - Reset mid-frame aborts that frame; nothing is latched or sent afterwards.
- RX input sync: RXD passes through a 2-flop synchronizer (rx_s), reset value 1. All RX decisions use rx_s.
- RX FSM, states IDLE, START, DATA, STOP:
  - IDLE: on rx_s==0 go to START and clear the timer.
  - START: after CLKS_PER_BIT/2 cycles sample rx_s.
    - 0: go to DATA, bit index=0.
    - 1: false start, return to IDLE.
  - DATA: every CLKS_PER_BIT cycles sample one bit, LSB first, into the shift register. After bit 7 go to STOP.
  - STOP: after CLKS_PER_BIT cycles sample rx_s.
    - 1: assert internal rx_valid for exactly one cycle with rx_byte.
    - 0: framing error; byte discarded, LED unchanged, no echo.
    - In both cases return to IDLE.
  - A new start bit is accepted in the cycle after STOP completes.
- LED: on the cycle after rx_valid, LED <= rx_byte. LED holds its value until the next valid byte or reset.
- Echo path (evaluated on rx_valid):
  - TX idle and buffer empty: TX loads the byte and starts next cycle.
  - TX busy and buffer empty: byte stored in buffer.
  - TX busy and buffer full: new byte dropped from echo; LED is still updated.
  - When TX returns to IDLE with the buffer full, it starts the buffered byte on the next cycle and the buffer empties.
  - rx_valid in the same cycle TX goes idle with the buffer full: the buffered byte is sent first and the new byte enters the buffer.
- TX FSM, states IDLE, START, DATA, STOP:
  - START: TXD=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, CLKS_PER_BIT cycles each.
  - STOP: TXD=1 for CLKS_PER_BIT cycles, then IDLE.
  - Total frame length 10*CLKS_PER_BIT cycles. TXD is registered (glitch-free).
  - Latency: first TXD low edge 1-3 cycles after rx_valid when TX is idle.
- Timing: RX sampling mid-bit tolerates +/-40% of a half bit period of skew. No parity, single stop bit.
- RXD undriven or unknown at simulation start is outside spec; benches drive RXD=1 when idle.

Test Plan:
- Reset: hold RST=0 for 5 cycles with RXD=1, release -> LED=8'h00 and TXD=1 continuously for 200 cycles; no activity.
- Single byte: send 0xA5 with CLKS_PER_BIT=8 -> LED=8'hA5 one cycle after the stop sample; TXD emits start, bits 1,0,1,0,0,1,0,1 (LSB first), stop; 80 cycles per frame.
- Back-to-back: send 0x12, 0x34, 0x56 with no idle gap ->
  - LED ends at 8'h56.
  - TXD echoes 0x12 then 0x34, contiguous.
  - 0x56 echo is dropped only if the buffer is still full when 0x56 arrives; the checker computes this from timing.
- Framing error: send 0x3C with the stop bit driven 0 -> LED keeps its previous value (0x00 after reset); TXD stays high.
- False start: pulse RXD low for 2 cycles, then high -> RX returns to IDLE; LED unchanged; TXD high. A following valid byte 0x81 -> LED=8'h81.
- Mid-frame reset: assert RST=0 during bit 4 of an incoming 0xFF, release, then send 0x07 -> LED=8'h07 and exactly one TX frame (0x07) appears.
